pipe_stage_skid: RTL

- Parametrised pipeline-stage register, successor to the fixed inter-stage latches (IF/ID … MEM/WB).
- Carries a control field and a data payload between stages with a valid/ready handshake, a two-entry skid buffer, a synchronous flush and a saturating stall counter.
- Full throughput with a registered in_ready, so hazard/stall logic no longer sees a combinational ready path through the stage.
- Instantiated between every pair of pipeline stages; CTRL_W and DATA_W are set per boundary.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_skid_if.sv | 16 +
 rtl/sat_counter.sv | 34 +++
 rtl/pipe_stage_skid.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and per-boundary widths for the pipeline-stage registers.
package pipe_pkg;

  // Occupancy of a stage: nothing held, main entry only, or main plus skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Per-boundary widths; each stage instance picks the pair for its boundary.
  localparam int unsigned IF_ID_CTRL_W  = 1;   // {valid_instr}
  localparam int unsigned IF_ID_DATA_W  = 64;  // pc 32 + instr 32
  localparam int unsigned ID_EX_CTRL_W  = 9;   // alu_op, alu_src, branch, mem_*, reg_*
  localparam int unsigned ID_EX_DATA_W  = 133; // pc 32 + rs 32 + rt 32 + imm 32 + reg_dest 5
  localparam int unsigned EX_MEM_CTRL_W = 5;   // branch, mem_read, mem_write, mem_to_reg, reg_write
  localparam int unsigned EX_MEM_DATA_W = 102; // alu 32 + store 32 + target 32 + zero 1 + reg_dest 5
  localparam int unsigned MEM_WB_CTRL_W = 2;   // {mem_to_reg, reg_write}
  localparam int unsigned MEM_WB_DATA_W = 69;  // read_data 32 + address 32 + reg_dest 5

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one control field and one payload.
interface pipe_stage_skid_if #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = 69
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  // Producer side drives the entry, consumer side drives ready.
  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  localparam logic [STAT_W-1:0] One = STAT_W'(1);

  logic [STAT_W-1:0] count_q, count_d;

  // Next count: step by one unless already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + One;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a two-entry skid buffer, registered in_ready,
// synchronous flush, bubble-masked control and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = MEM_WB_CTRL_W,
  parameter int unsigned DATA_W = MEM_WB_DATA_W,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_skid_if.slave  in_if,
  pipe_stage_skid_if.master out_if,
  output logic [STAT_W-1:0] stall_cnt
);

  skid_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Both flags decode straight from the state flop, so ready has no path from out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_if.valid & in_ready;
  assign pop       = out_valid & out_if.ready;

  // State and entry registers; reset drops anything held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Next state and entry moves; skid only ever refills main, keeping FIFO order.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Flush beats a same-cycle push; payload is left in place as the idle value.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_ctrl_d = in_if.ctrl;
            main_data_d = in_if.data;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_ctrl_d = in_if.ctrl;
            main_data_d = in_if.data;
          end else if (push) begin
            skid_ctrl_d = in_if.ctrl;
            skid_data_d = in_if.data;
            state_d     = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Outputs; control is zeroed on bubbles so an idle slot never writes anything.
  always_comb begin
    in_if.ready  = in_ready;
    out_if.valid = out_valid;
    out_if.ctrl  = out_valid ? main_ctrl_q : '0;
    out_if.data  = main_data_q;
  end

  sat_counter #(
    .STAT_W(STAT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_if.ready),
    .count(stall_cnt)
  );

endmodule
